// File: rtl/tx_frame_scheduler_if.sv
// ----------------------------------------------------------------------------
// tx_frame_scheduler_if
// Command/completion bus between the frame scheduler and the UDP/ARP TX
// engine.
//   tx_cmd_valid  scheduler -> engine  command valid
//   tx_cmd_ready  engine -> scheduler  engine accepts the command
//   tx_cmd_type   scheduler -> engine  00=ARP, 01=motor, 10=AD
//   tx_cmd_addr   scheduler -> engine  frame buffer base address
//   tx_cmd_len    scheduler -> engine  payload length in bytes
//   tx_done       engine -> scheduler  frame finished pulse
// master = scheduler side, slave = engine side.
// ----------------------------------------------------------------------------
interface tx_frame_scheduler_if #(
  parameter int C_AXI_ADDR_WIDTH = 32
) ();

  logic                        tx_cmd_valid;
  logic                        tx_cmd_ready;
  logic [1:0]                  tx_cmd_type;
  logic [C_AXI_ADDR_WIDTH-1:0] tx_cmd_addr;
  logic [15:0]                 tx_cmd_len;
  logic                        tx_done;

  modport master (
    output tx_cmd_valid,
    output tx_cmd_type,
    output tx_cmd_addr,
    output tx_cmd_len,
    input  tx_cmd_ready,
    input  tx_done
  );

  modport slave (
    input  tx_cmd_valid,
    input  tx_cmd_type,
    input  tx_cmd_addr,
    input  tx_cmd_len,
    output tx_cmd_ready,
    output tx_done
  );

endinterface

// File: rtl/tx_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tx_frame_scheduler
// Shares the single UDP/ARP transmit engine between ARP replies, the motor
// status channel and the AD sample channel. One command is outstanding at a
// time; after completion an inter-frame gap is inserted before the next
// grant, and a watchdog recovers the scheduler if the engine never finishes.
//
// Ports
//   sys_clk             system clock
//   sys_rst_n           asynchronous active-low reset
//   trig_package_rst_i  synchronous abort pulse (returns to IDLE)
//   trig_arp_i          ARP reply request pulse
//   motor_req_i         motor frame request level, held until grant_motor_o
//   motor_len_i         motor payload bytes
//   ad_req_i            AD frame request level, held until grant_ad_o
//   ad_len_i            AD payload bytes
//   tx_if               command/completion bus to the TX engine (master)
//   grant_motor_o       one-cycle pulse: motor request consumed
//   grant_ad_o          one-cycle pulse: AD request consumed
//   timeout_err_o       one-cycle pulse: watchdog fired
//   sched_busy_o        high whenever the scheduler is not IDLE
// ----------------------------------------------------------------------------
module tx_frame_scheduler #(
  parameter int                          C_AXI_ADDR_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] C_ADDR_MOTOR2ETH = 32'h0000_0000,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] C_ADDR_AD2ETH    = 32'h1000_0000,
  parameter logic [15:0]                 MAX_PAYLOAD      = 16'd1472,
  parameter int                          IFG_CYCLES       = 12,
  parameter int                          WATCH_DOG_WIDTH  = 12
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  trig_package_rst_i,
  input  logic                  trig_arp_i,
  input  logic                  motor_req_i,
  input  logic [15:0]           motor_len_i,
  input  logic                  ad_req_i,
  input  logic [15:0]           ad_len_i,
  tx_frame_scheduler_if.master  tx_if,
  output logic                  grant_motor_o,
  output logic                  grant_ad_o,
  output logic                  timeout_err_o,
  output logic                  sched_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_BUSY,
    S_GAP
  } state_t;

  localparam logic [1:0] TYPE_ARP   = 2'b00;
  localparam logic [1:0] TYPE_MOTOR = 2'b01;
  localparam logic [1:0] TYPE_AD    = 2'b10;

  // Watchdog fires on the cycle its count would reach all-ones, so the
  // scheduler spends exactly 2^WATCH_DOG_WIDTH-1 cycles in BUSY.
  localparam logic [WATCH_DOG_WIDTH-1:0] WD_LAST = {{(WATCH_DOG_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [15:0] GAP_LAST = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
  localparam bit HAS_GAP = (IFG_CYCLES > 0);

  state_t                      state_q, state_d;
  logic                        arpPend_q, arpPend_d;
  logic                        lastAd_q, lastAd_d;
  logic                        cmdValid_q, cmdValid_d;
  logic [1:0]                  cmdType_q, cmdType_d;
  logic [C_AXI_ADDR_WIDTH-1:0] cmdAddr_q, cmdAddr_d;
  logic [15:0]                 cmdLen_q, cmdLen_d;
  logic                        grantMotor_q, grantMotor_d;
  logic                        grantAd_q, grantAd_d;
  logic                        timeoutErr_q, timeoutErr_d;
  logic [WATCH_DOG_WIDTH-1:0]  wdog_q, wdog_d;
  logic [15:0]                 gap_q, gap_d;

  logic [15:0] motorLenClamped;
  logic [15:0] adLenClamped;
  logic        motorEff;
  logic        adEff;
  logic        pickMotor;
  logic        pickAd;
  state_t      afterBusy;

  assign motorLenClamped = (motor_len_i > MAX_PAYLOAD) ? MAX_PAYLOAD : motor_len_i;
  assign adLenClamped    = (ad_len_i > MAX_PAYLOAD) ? MAX_PAYLOAD : ad_len_i;

  // A requester sees its grant one cycle late and is still high during the
  // grant cycle; masking it there keeps a zero-length grant from being
  // consumed twice while the scheduler sits in IDLE.
  assign motorEff = motor_req_i & ~grantMotor_q;
  assign adEff    = ad_req_i & ~grantAd_q;

  // Round-robin between motor and AD: a lone requester always wins, on a tie
  // the channel not served last wins.
  assign pickMotor = motorEff & (~adEff | lastAd_q);
  assign pickAd    = adEff & ~pickMotor;

  assign afterBusy = HAS_GAP ? S_GAP : S_IDLE;

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      arpPend_q    <= 1'b0;
      lastAd_q     <= 1'b1;
      cmdValid_q   <= 1'b0;
      cmdType_q    <= TYPE_ARP;
      cmdAddr_q    <= '0;
      cmdLen_q     <= '0;
      grantMotor_q <= 1'b0;
      grantAd_q    <= 1'b0;
      timeoutErr_q <= 1'b0;
      wdog_q       <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      arpPend_q    <= arpPend_d;
      lastAd_q     <= lastAd_d;
      cmdValid_q   <= cmdValid_d;
      cmdType_q    <= cmdType_d;
      cmdAddr_q    <= cmdAddr_d;
      cmdLen_q     <= cmdLen_d;
      grantMotor_q <= grantMotor_d;
      grantAd_q    <= grantAd_d;
      timeoutErr_q <= timeoutErr_d;
      wdog_q       <= wdog_d;
      gap_q        <= gap_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    arpPend_d    = arpPend_q | trig_arp_i;
    lastAd_d     = lastAd_q;
    cmdValid_d   = cmdValid_q;
    cmdType_d    = cmdType_q;
    cmdAddr_d    = cmdAddr_q;
    cmdLen_d     = cmdLen_q;
    grantMotor_d = 1'b0;
    grantAd_d    = 1'b0;
    timeoutErr_d = 1'b0;
    wdog_d       = wdog_q;
    gap_d        = gap_q;

    if (trig_package_rst_i) begin
      // Abort wins over everything else this cycle; last_grant is kept.
      state_d    = S_IDLE;
      cmdValid_d = 1'b0;
      arpPend_d  = 1'b0;
      wdog_d     = '0;
      gap_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arpPend_q) begin
            state_d    = S_CMD;
            cmdValid_d = 1'b1;
            cmdType_d  = TYPE_ARP;
            cmdAddr_d  = '0;
            cmdLen_d   = '0;
          end else if (pickMotor) begin
            if (motor_len_i == 16'd0) begin
              // Empty frame: consume the request without using the engine.
              grantMotor_d = 1'b1;
              lastAd_d     = 1'b0;
            end else begin
              state_d    = S_CMD;
              cmdValid_d = 1'b1;
              cmdType_d  = TYPE_MOTOR;
              cmdAddr_d  = C_ADDR_MOTOR2ETH;
              cmdLen_d   = motorLenClamped;
            end
          end else if (pickAd) begin
            if (ad_len_i == 16'd0) begin
              grantAd_d = 1'b1;
              lastAd_d  = 1'b1;
            end else begin
              state_d    = S_CMD;
              cmdValid_d = 1'b1;
              cmdType_d  = TYPE_AD;
              cmdAddr_d  = C_ADDR_AD2ETH;
              cmdLen_d   = adLenClamped;
            end
          end
        end

        S_CMD: begin
          if (tx_if.tx_cmd_ready) begin
            state_d    = S_BUSY;
            cmdValid_d = 1'b0;
            wdog_d     = '0;
            case (cmdType_q)
              TYPE_MOTOR: begin
                grantMotor_d = 1'b1;
                lastAd_d     = 1'b0;
              end
              TYPE_AD: begin
                grantAd_d = 1'b1;
                lastAd_d  = 1'b1;
              end
              default: begin
                // A fresh trig_arp on the accept cycle keeps ARP pending.
                arpPend_d = trig_arp_i;
              end
            endcase
          end
        end

        S_BUSY: begin
          if (tx_if.tx_done) begin
            state_d = afterBusy;
            wdog_d  = '0;
            gap_d   = '0;
          end else if (wdog_q == WD_LAST) begin
            state_d      = afterBusy;
            timeoutErr_d = 1'b1;
            wdog_d       = '0;
            gap_d        = '0;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = S_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign tx_if.tx_cmd_valid = cmdValid_q;
  assign tx_if.tx_cmd_type  = cmdType_q;
  assign tx_if.tx_cmd_addr  = cmdAddr_q;
  assign tx_if.tx_cmd_len   = cmdLen_q;

  assign grant_motor_o = grantMotor_q;
  assign grant_ad_o    = grantAd_q;
  assign timeout_err_o = timeoutErr_q;
  assign sched_busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_tx_frame_scheduler
// Directed bench for tx_frame_scheduler. Expected commands are queued when a
// request is driven and popped when the scheduler raises tx_cmd_valid. The
// round-robin winner is tracked with a one-bit model of the last channel
// served. Inputs change and outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tx_frame_scheduler;

  typedef struct {
    logic [1:0]  cmdType;
    logic [31:0] cmdAddr;
    logic [15:0] cmdLen;
  } cmd_t;

  localparam logic [1:0] T_ARP   = 2'b00;
  localparam logic [1:0] T_MOTOR = 2'b01;
  localparam logic [1:0] T_AD    = 2'b10;
  localparam logic [31:0] ADDR_MOTOR = 32'h0000_0000;
  localparam logic [31:0] ADDR_AD    = 32'h1000_0000;
  localparam logic [15:0] MAX_PL     = 16'd1472;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        trigPackageRst;
  logic        trigArp;
  logic        motorReq;
  logic [15:0] motorLen;
  logic        adReq;
  logic [15:0] adLen;
  logic        grantMotor;
  logic        grantAd;
  logic        timeoutErr;
  logic        schedBusy;

  int   checks = 0;
  int   errors = 0;
  cmd_t expQ[$];
  logic modelLastAd;

  tx_frame_scheduler_if #(.C_AXI_ADDR_WIDTH(32)) txIf ();

  tx_frame_scheduler dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .trig_package_rst_i (trigPackageRst),
    .trig_arp_i         (trigArp),
    .motor_req_i        (motorReq),
    .motor_len_i        (motorLen),
    .ad_req_i           (adReq),
    .ad_len_i           (adLen),
    .tx_if              (txIf),
    .grant_motor_o      (grantMotor),
    .grant_ad_o         (grantAd),
    .timeout_err_o      (timeoutErr),
    .sched_busy_o       (schedBusy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance one clock; land 1 ns after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic mReq, input logic [15:0] mLen,
                               input logic aReq, input logic [15:0] aLen);
    motorReq = mReq;
    motorLen = mLen;
    adReq    = aReq;
    adLen    = aLen;
  endtask

  function automatic logic [15:0] clampLen(input logic [15:0] len);
    return (len > MAX_PL) ? MAX_PL : len;
  endfunction

  task automatic pushExp(input logic [1:0] t, input logic [15:0] len);
    cmd_t c;
    c.cmdType = t;
    c.cmdAddr = (t == T_MOTOR) ? ADDR_MOTOR : ((t == T_AD) ? ADDR_AD : 32'h0);
    c.cmdLen  = (t == T_ARP) ? 16'd0 : clampLen(len);
    expQ.push_back(c);
  endtask

  // Wait (bounded) for tx_cmd_valid, then compare against the queue head.
  task automatic expectCmd(input string tag, input int budget);
    cmd_t e;
    int   n = 0;
    while (txIf.tx_cmd_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 64'(txIf.tx_cmd_valid), 64'd1);
    checkOutput({tag, "_sbHasEntry"}, 64'(expQ.size() > 0), 64'd1);
    if (txIf.tx_cmd_valid === 1'b1 && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({tag, "_type"}, 64'(txIf.tx_cmd_type), 64'(e.cmdType));
      checkOutput({tag, "_addr"}, 64'(txIf.tx_cmd_addr), 64'(e.cmdAddr));
      checkOutput({tag, "_len"},  64'(txIf.tx_cmd_len),  64'(e.cmdLen));
    end
  endtask

  task automatic waitIdle(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (schedBusy !== 1'b0 && cycles < budget) begin
      tick();
      cycles++;
    end
    checkOutput(tag, 64'(schedBusy), 64'd0);
  endtask

  task automatic pulseDone();
    txIf.tx_done = 1'b1;
    tick();
    txIf.tx_done = 1'b0;
  endtask

  initial begin
    int         n;
    logic [1:0] winner;
    logic [1:0] other;

    sys_rst_n         = 1'b0;
    trigPackageRst    = 1'b0;
    trigArp           = 1'b0;
    txIf.tx_cmd_ready = 1'b0;
    txIf.tx_done      = 1'b0;
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    modelLastAd = 1'b1;

    // Reset state.
    #2;
    checkOutput("rst_valid", 64'(txIf.tx_cmd_valid), 64'd0);
    checkOutput("rst_type",  64'(txIf.tx_cmd_type), 64'd0);
    checkOutput("rst_addr",  64'(txIf.tx_cmd_addr), 64'd0);
    checkOutput("rst_len",   64'(txIf.tx_cmd_len), 64'd0);
    checkOutput("rst_gm",    64'(grantMotor), 64'd0);
    checkOutput("rst_ga",    64'(grantAd), 64'd0);
    checkOutput("rst_to",    64'(timeoutErr), 64'd0);
    checkOutput("rst_busy",  64'(schedBusy), 64'd0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();

    // Single motor request: 1-cycle latency, grant, 12-cycle gap.
    $display("[TB] single motor frame");
    pushExp(T_MOTOR, 16'd100);
    applyStimulus(1'b1, 16'd100, 1'b0, 16'd0);
    tick();
    checkOutput("t1_latency", 64'(txIf.tx_cmd_valid), 64'd1);
    expectCmd("t1", 0);
    txIf.tx_cmd_ready = 1'b1;
    tick();
    modelLastAd = 1'b0;
    checkOutput("t1_grant", 64'(grantMotor), 64'd1);
    checkOutput("t1_validDrop", 64'(txIf.tx_cmd_valid), 64'd0);
    checkOutput("t1_busy", 64'(schedBusy), 64'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    txIf.tx_cmd_ready = 1'b0;
    tick();
    checkOutput("t1_grantOnce", 64'(grantMotor), 64'd0);
    pulseDone();
    waitIdle("t1_idle", 40, n);
    checkOutput("t1_gapCycles", 64'(n), 64'd12);

    // Both channels held: round-robin alternation.
    $display("[TB] round-robin motor/AD");
    txIf.tx_cmd_ready = 1'b1;
    applyStimulus(1'b1, 16'd64, 1'b1, 16'd64);
    for (int i = 0; i < 4; i++) begin
      winner = modelLastAd ? T_MOTOR : T_AD;
      pushExp(winner, 16'd64);
      expectCmd($sformatf("rr%0d", i), 30);
      tick();
      modelLastAd = (winner == T_AD);
      checkOutput($sformatf("rr%0d_gm", i), 64'(grantMotor), 64'(winner == T_MOTOR));
      checkOutput($sformatf("rr%0d_ga", i), 64'(grantAd), 64'(winner == T_AD));
      for (int k = 0; k < 4; k++) tick();
      if (i == 3) applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
      pulseDone();
    end
    waitIdle("rr_idle", 40, n);

    // ARP preempts pending motor/AD; ARP on accept cycle stays pending.
    $display("[TB] ARP priority");
    txIf.tx_cmd_ready = 1'b0;
    winner = modelLastAd ? T_MOTOR : T_AD;
    other  = (winner == T_MOTOR) ? T_AD : T_MOTOR;
    pushExp(winner, 16'd64);
    applyStimulus(1'b1, 16'd64, 1'b1, 16'd64);
    expectCmd("arp_first", 10);
    txIf.tx_cmd_ready = 1'b1;
    tick();
    modelLastAd = (winner == T_AD);
    if (winner == T_MOTOR) motorReq = 1'b0;
    else adReq = 1'b0;
    pushExp(T_ARP, 16'd0);
    trigArp = 1'b1;
    tick();
    trigArp = 1'b0;
    tick();
    pulseDone();
    expectCmd("arp1", 30);
    pushExp(T_ARP, 16'd0);
    trigArp = 1'b1;
    tick();
    trigArp = 1'b0;
    checkOutput("arp1_noGm", 64'(grantMotor), 64'd0);
    checkOutput("arp1_noGa", 64'(grantAd), 64'd0);
    tick();
    pulseDone();
    expectCmd("arp2", 30);
    tick();
    tick();
    pulseDone();
    pushExp(other, 16'd64);
    expectCmd("arp_other", 30);
    tick();
    modelLastAd = (other == T_AD);
    checkOutput("arp_other_grant", 64'((other == T_MOTOR) ? grantMotor : grantAd), 64'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    pulseDone();
    waitIdle("arp_idle", 40, n);

    // Clamping and zero-length requests.
    $display("[TB] length boundaries");
    pushExp(T_AD, 16'd2000);
    applyStimulus(1'b0, 16'd0, 1'b1, 16'd2000);
    expectCmd("clamp", 10);
    tick();
    modelLastAd = 1'b1;
    checkOutput("clamp_grant", 64'(grantAd), 64'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    pulseDone();
    waitIdle("clamp_idle", 40, n);
    applyStimulus(1'b1, 16'd0, 1'b0, 16'd0);
    tick();
    modelLastAd = 1'b0;
    checkOutput("zero_grant", 64'(grantMotor), 64'd1);
    checkOutput("zero_noValid", 64'(txIf.tx_cmd_valid), 64'd0);
    checkOutput("zero_idle", 64'(schedBusy), 64'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    tick();
    checkOutput("zero_grantOnce", 64'(grantMotor), 64'd0);
    checkOutput("zero_noValid2", 64'(txIf.tx_cmd_valid), 64'd0);

    // Watchdog: accept and never complete.
    $display("[TB] watchdog");
    pushExp(T_MOTOR, 16'd10);
    applyStimulus(1'b1, 16'd10, 1'b0, 16'd0);
    expectCmd("wd", 10);
    tick();
    modelLastAd = 1'b0;
    checkOutput("wd_grant", 64'(grantMotor), 64'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    txIf.tx_cmd_ready = 1'b0;
    n = 0;
    while (timeoutErr !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    checkOutput("wd_fired", 64'(timeoutErr), 64'd1);
    checkOutput("wd_cycles", 64'(n), 64'd4095);
    tick();
    checkOutput("wd_pulseOnce", 64'(timeoutErr), 64'd0);
    waitIdle("wd_idle", 40, n);
    checkOutput("wd_gapRest", 64'(n), 64'd11);
    txIf.tx_cmd_ready = 1'b1;
    pushExp(T_MOTOR, 16'd20);
    applyStimulus(1'b1, 16'd20, 1'b0, 16'd0);
    expectCmd("wd_after", 10);
    tick();
    modelLastAd = 1'b0;
    checkOutput("wd_after_grant", 64'(grantMotor), 64'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    pulseDone();
    waitIdle("wd_after_idle", 40, n);

    // Abort while the engine stalls in CMD.
    $display("[TB] abort and async reset");
    txIf.tx_cmd_ready = 1'b0;
    pushExp(T_AD, 16'd30);
    applyStimulus(1'b0, 16'd0, 1'b1, 16'd30);
    expectCmd("abort", 10);
    trigPackageRst = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    tick();
    trigPackageRst = 1'b0;
    checkOutput("abort_valid", 64'(txIf.tx_cmd_valid), 64'd0);
    checkOutput("abort_busy", 64'(schedBusy), 64'd0);
    checkOutput("abort_noGrant", 64'(grantAd), 64'd0);
    tick();
    checkOutput("abort_noGrant2", 64'(grantAd), 64'd0);

    // Async reset in the grant cycle of a BUSY frame.
    txIf.tx_cmd_ready = 1'b1;
    pushExp(T_MOTOR, 16'd40);
    applyStimulus(1'b1, 16'd40, 1'b0, 16'd0);
    expectCmd("rstBusy", 10);
    tick();
    checkOutput("rstBusy_grant", 64'(grantMotor), 64'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    modelLastAd = 1'b1;
    checkOutput("rstBusy_busy", 64'(schedBusy), 64'd0);
    checkOutput("rstBusy_gm", 64'(grantMotor), 64'd0);
    checkOutput("rstBusy_valid", 64'(txIf.tx_cmd_valid), 64'd0);
    checkOutput("rstBusy_len", 64'(txIf.tx_cmd_len), 64'd0);
    checkOutput("rstBusy_to", 64'(timeoutErr), 64'd0);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);
    tick();
    sys_rst_n = 1'b1;
    tick();

    // After reset the motor channel wins the first tie.
    pushExp(modelLastAd ? T_MOTOR : T_AD, 16'd8);
    applyStimulus(1'b1, 16'd8, 1'b1, 16'd8);
    expectCmd("postRst_tie", 10);
    applyStimulus(1'b0, 16'd0, 1'b0, 16'd0);

    checkOutput("sb_empty", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
Arbitrates the single UDP/ARP transmit engine among three frame sources: ARP replies, the motor-status channel and the AD-sample channel. It issues one frame command at a time to the TX engine and waits for completion. It then enforces an inter-frame gap before the next grant. A watchdog recovers the scheduler if the engine never reports completion.

Parameters:
C_AXI_ADDR_WIDTH, 32, width of tx_cmd_addr
C_ADDR_MOTOR2ETH, 32'h0000_0000, buffer base address issued for motor frames
C_ADDR_AD2ETH, 32'h1000_0000, buffer base address issued for AD frames
MAX_PAYLOAD, 16'd1472, largest UDP payload in bytes; longer requests are clamped
IFG_CYCLES, 12, idle cycles between tx_done and the next command (0 allowed)
WATCH_DOG_WIDTH, 12, width of the BUSY-state watchdog counter

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
trig_package_rst  in  1  synchronous abort pulse
trig_arp  in  1  ARP reply request pulse
motor_req  in  1  motor frame request, level; held until grant_motor
motor_len  in  16  motor payload bytes, valid while motor_req=1
ad_req  in  1  AD frame request, level; held until grant_ad
ad_len  in  16  AD payload bytes
tx_cmd_valid  out  1  command valid
tx_cmd_ready  in  1  TX engine accepts command
tx_cmd_type  out  2  00=ARP, 01=motor, 10=AD
tx_cmd_addr  out  C_AXI_ADDR_WIDTH  buffer base address (0 for ARP)
tx_cmd_len  out  16  payload bytes (0 for ARP)
tx_done  in  1  frame finished pulse
grant_motor  out  1  one-cycle pulse: motor request consumed
grant_ad  out  1  one-cycle pulse: AD request consumed
timeout_err  out  1  one-cycle pulse: watchdog fired
sched_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sys_rst_n=0, async): state IDLE. All outputs 0. arp_pend=0. last_grant=AD, so motor wins the first tie. Counters 0.
- arp_pend is set by trig_arp and cleared on acceptance of an ARP command. If trig_arp arrives in the same cycle as that acceptance, arp_pend stays set.
- States: IDLE, CMD, BUSY, GAP.
- IDLE: if arp_pend or any req, latch the winner and go to CMD. The registered command appears on the next cycle, so latency from request to tx_cmd_valid is 1 cycle.
- Priority: ARP first. Between motor and AD, round-robin against last_grant. A single requester always wins.
- Length rule: len > MAX_PAYLOAD is clamped to MAX_PAYLOAD.
- Zero-length request: len == 0 emits the grant pulse but issues no command. The scheduler returns to IDLE, last_grant is updated, and no gap is applied.
- CMD: tx_cmd_valid=1. type, addr and len stay stable until tx_cmd_ready. On the handshake cycle: tx_cmd_valid drops next cycle, go to BUSY, and update last_grant for motor/AD.
- grant_motor / grant_ad pulse for one cycle, the cycle after the handshake. Requesters drop req on grant; a req still high after grant is treated as a new request.
- BUSY: the watchdog increments every cycle. tx_done moves to GAP and clears the watchdog. When the watchdog reaches all-ones (2^WATCH_DOG_WIDTH-1 cycles) without tx_done: timeout_err pulses once, go to GAP.
- GAP: counts IFG_CYCLES cycles, then IDLE. IFG_CYCLES=0 goes from BUSY straight to IDLE.
- tx_done outside BUSY is ignored.
- trig_package_rst (any state): next state IDLE; tx_cmd_valid deasserts next cycle; counters and arp_pend clear; no grant pulse is issued; last_grant is retained. It has priority over all other events in the same cycle.
- sched_busy = (state != IDLE).

Test Plan:
- Reset then motor_req=1, motor_len=100 -> tx_cmd_valid at cycle +1 with type=01, addr=32'h0, len=100. With ready=1: grant_motor pulses one cycle later. tx_done -> 12 gap cycles -> IDLE.
- motor_req and ad_req both held with len=64, engine always ready, tx_done 5 cycles after each accept -> command types alternate 01,10,01,10.
- trig_arp pulsed while motor and AD are pending during BUSY -> next command type=00, len=0. A second trig_arp on the ARP accept cycle -> another ARP command follows.
- ad_len=2000 -> tx_cmd_len=1472, addr=32'h1000_0000. motor_len=0 -> grant_motor pulse, no tx_cmd_valid.
- Accept a command and never assert tx_done -> timeout_err pulses after 4095 BUSY cycles, then the gap, then IDLE; next request is served normally.
- Hold tx_cmd_ready=0 in CMD and pulse trig_package_rst -> tx_cmd_valid=0 next cycle, sched_busy=0, no grant pulse. Assert sys_rst_n=0 mid-BUSY -> all outputs 0 immediately.
